// File: rtl/led_pattern_sequencer.sv
// Autonomous bus master: paces through a small pattern table and writes each
// 16-bit entry to the LED register pair as two byte writes over a REQ/GNT shared bus.
module led_pattern_sequencer #(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         DEPTH     = 4,
    parameter int         PERIOD_W  = 16,
    localparam int        IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                EN,
    input  logic [PERIOD_W-1:0] PERIOD,
    input  logic                PAT_WR,
    input  logic [IDX_W-1:0]    PAT_IDX,
    input  logic [15:0]         PAT_DATA,
    output logic                BUS_REQ,
    input  logic                BUS_GNT,
    output logic [7:0]          BUS_ADDR,
    output logic [7:0]          BUS_DATA_OUT,
    output logic                BUS_WE,
    output logic [IDX_W-1:0]    STEP,
    output logic                BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]      step_q, step_d;
    logic [15:0]           snap_q, snap_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [15:0]           table_q [DEPTH];
    logic [PERIOD_W-1:0]   period_m1;
    logic                  tick;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_table
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    table_q[gi] <= 16'h0000;
                end else if (PAT_WR && (PAT_IDX == IDX_W'(gi))) begin
                    table_q[gi] <= PAT_DATA;
                end
            end
        end
    endgenerate

    // PERIOD of zero behaves like one: the first IDLE cycle already ticks.
    assign period_m1 = (PERIOD == '0) ? '0 : PERIOD - PERIOD_W'(1);
    assign tick      = (timer_q == period_m1);

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        step_d  = step_q;
        snap_d  = snap_q;
        unique case (state_q)
            S_IDLE: begin
                if (EN) begin
                    if (tick) begin
                        state_d = S_REQ;
                    end else begin
                        timer_d = timer_q + PERIOD_W'(1);
                    end
                end
            end
            S_REQ: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end else if (BUS_GNT) begin
                    snap_d  = table_q[step_q];
                    state_d = S_WR_LO;
                end
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: state_d = S_DONE;
            S_DONE: begin
                step_d  = step_q + IDX_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request follows the next state; the write beats trail the state by one
    // cycle so data is driven only after the grant edge has been consumed.
    always_comb begin
        req_d  = (state_d != S_IDLE);
        we_d   = 1'b0;
        addr_d = 8'h00;
        data_d = 8'h00;
        if (state_q == S_WR_LO) begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR;
            data_d = snap_q[7:0];
        end else if (state_q == S_WR_HI) begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR + 8'd1;
            data_d = snap_q[15:8];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            step_q  <= '0;
            snap_q  <= 16'h0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            snap_q  <= snap_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign BUS_REQ      = req_q;
    assign BUS_WE       = we_q;
    assign BUS_ADDR     = addr_q;
    assign BUS_DATA_OUT = data_q;
    assign STEP         = step_q;
    assign BUSY         = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected bus beats are queued when
// a step is set up and a negedge monitor pops them against every write cycle.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] period;
    logic        pat_wr;
    logic [1:0]  pat_idx;
    logic [15:0] pat_data;
    logic        bus_req;
    logic        bus_gnt;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        bus_we;
    logic [1:0]  step;
    logic        busy;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] tab [4];
    int          m_step;
    int          vectors = 0;
    int          miscompares = 0;

    logic        manual = 1'b0;
    logic        gnt_man = 1'b0;
    logic        gnt_auto = 1'b0;
    int          gnt_delay = 0;
    int          wcnt = 0;

    led_pattern_sequencer dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .EN           (en),
        .PERIOD       (period),
        .PAT_WR       (pat_wr),
        .PAT_IDX      (pat_idx),
        .PAT_DATA     (pat_data),
        .BUS_REQ      (bus_req),
        .BUS_GNT      (bus_gnt),
        .BUS_ADDR     (bus_addr),
        .BUS_DATA_OUT (bus_data),
        .BUS_WE       (bus_we),
        .STEP         (step),
        .BUSY         (busy)
    );

    always #5 clk = ~clk;

    // Arbiter: grant after gnt_delay extra cycles of request, held while requested.
    always @(posedge clk) begin
        if (!bus_req) begin
            gnt_auto <= 1'b0;
            wcnt     <= 0;
        end else if (wcnt >= gnt_delay) begin
            gnt_auto <= 1'b1;
        end else begin
            wcnt <= wcnt + 1;
        end
    end
    assign bus_gnt = manual ? gnt_man : gnt_auto;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                         bus_addr, bus_data, $time);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("bus_addr", {24'd0, bus_addr}, {24'd0, b.addr});
                chk("bus_data", {24'd0, bus_data}, {24'd0, b.data});
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_pat(input logic [1:0] idx, input logic [15:0] data);
        pat_wr   = 1'b1;
        pat_idx  = idx;
        pat_data = data;
        tab[idx] = data;
        @(negedge clk);
        pat_wr = 1'b0;
    endtask

    task automatic push_step(input int idx);
        exp_q.push_back('{8'hC0, tab[idx][7:0]});
        exp_q.push_back('{8'hC1, tab[idx][15:8]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) tab[i] = 16'h0000;
        m_step = 0;
        tick_n(3);
        rst_n = 1'b1;
        tick_n(1);
    endtask

    // Waits for STEP to move, then checks it against the model's next index.
    task automatic wait_step(input string name);
        logic [1:0] old;
        bit         seen;
        old  = step;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (step !== old) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: got STEP stuck at %0d, expected %0d", name, old, (m_step + 1) % 4);
        end else begin
            chk(name, {30'd0, step}, (m_step + 1) % 4);
        end
        m_step = (m_step + 1) % 4;
    endtask

    task automatic wait_req(input string name, output int cycles);
        cycles = 0;
        while (bus_req !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        if (bus_req !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: got BUS_REQ=0, expected 1", name);
        end
    endtask

    task automatic wait_we(input string name);
        int c;
        c = 0;
        while (bus_we !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (bus_we !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: got BUS_WE=0, expected 1", name);
        end
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        en       = 1'b0;
        period   = 16'd0;
        pat_wr   = 1'b0;
        pat_idx  = 2'd0;
        pat_data = 16'h0000;
        for (int i = 0; i < 4; i++) tab[i] = 16'h0000;
        m_step = 0;

        // Reset and idle with EN low
        tick_n(4);
        chk("in_reset", {bus_req, bus_we, busy, bus_addr, bus_data, step}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", {bus_req, bus_we, busy, bus_addr, bus_data, step}, 32'd0);
        end

        // Basic step: BUS_REQ exactly PERIOD cycles after EN is first sampled
        write_pat(2'd0, 16'hF00F);
        period = 16'd10;
        push_step(0);
        en = 1'b1;
        wait_req("basic_req", cyc);
        chk("req_latency", cyc, 10);
        wait_step("basic_step");
        chk("basic_req_drop", {31'd0, bus_req}, 32'd0);
        en = 1'b0;
        tick_n(5);

        // Wrap and order
        do_reset();
        write_pat(2'd0, 16'h0001);
        write_pat(2'd1, 16'h0002);
        write_pat(2'd2, 16'h0004);
        write_pat(2'd3, 16'h0008);
        period = 16'd3;
        push_step(0); push_step(1); push_step(2); push_step(3); push_step(0);
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_step("wrap_step");
            if (k == 4) en = 1'b0;
        end
        tick_n(10);
        chk("wrap_idle", {30'd0, busy, bus_req}, 32'd0);

        // Grant stall for 50 cycles, then exact write latency after grant
        manual  = 1'b1;
        gnt_man = 1'b0;
        period  = 16'd2;
        push_step(m_step);
        en = 1'b1;
        wait_req("stall_req", cyc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("stall", {30'd0, bus_req, bus_we}, 32'h2);
        end
        gnt_man = 1'b1;
        @(negedge clk);
        chk("we_after_n", {31'd0, bus_we}, 32'd0);
        @(negedge clk);
        chk("we_after_n1", {31'd0, bus_we}, 32'd1);
        @(negedge clk);
        chk("we_after_n2", {31'd0, bus_we}, 32'd1);
        @(negedge clk);
        chk("req_after_n3", {31'd0, bus_req}, 32'd0);
        chk("stall_step", {30'd0, step}, (m_step + 1) % 4);
        m_step  = (m_step + 1) % 4;
        en      = 1'b0;
        gnt_man = 1'b0;
        tick_n(5);

        // EN dropped while requesting: back to IDLE, STEP held
        en = 1'b1;
        wait_req("drop_req", cyc);
        tick_n(3);
        chk("drop_req_held", {31'd0, bus_req}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("drop_req_release", {30'd0, bus_req, busy}, 32'd0);
        chk("drop_step", {30'd0, step}, m_step);
        tick_n(5);
        manual = 1'b0;

        // Snapshot: table write during WR_LO does not affect the pair; EN dropped in WR_LO
        do_reset();
        write_pat(2'd0, 16'hF00F);
        period    = 16'd2;
        gnt_delay = 0;
        push_step(0);
        en = 1'b1;
        wait_we("snap_we");
        pat_wr   = 1'b1;
        pat_idx  = 2'd0;
        pat_data = 16'hAAAA;
        tab[0]   = 16'hAAAA;
        en       = 1'b0;
        @(negedge clk);
        pat_wr = 1'b0;
        chk("wr_hi_after_en_drop", {31'd0, bus_we}, 32'd1);
        wait_step("snap_step");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stay_idle", {30'd0, busy, bus_req}, 32'd0);
        end
        push_step(1); push_step(2); push_step(3); push_step(0);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_step("revisit_step");
            if (k == 3) en = 1'b0;
        end
        tick_n(5);

        // Asynchronous reset in the middle of WR_HI
        exp_q.push_back('{8'hC0, tab[m_step][7:0]});
        en = 1'b1;
        wait_we("areset_we");
        @(posedge clk);
        #1;
        chk("pre_reset_addr", {24'd0, bus_addr}, 32'hC1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_bus", {bus_req, bus_we, busy, bus_addr, bus_data}, 32'd0);
        chk("async_reset_step", {30'd0, step}, 32'd0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) tab[i] = 16'h0000;
        m_step = 0;
        tick_n(3);
        rst_n = 1'b1;
        tick_n(2);

        // Randomized steps: random table writes, PERIOD and grant delay between steps
        for (int it = 0; it < 25; it++) begin
            int nw;
            period    = 16'($urandom_range(0, 6));
            gnt_delay = $urandom_range(0, 4);
            nw        = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                write_pat(2'($urandom_range(0, 3)), 16'($urandom));
            end
            push_step(m_step);
            en = 1'b1;
            wait_step("rand_step");
        end
        en = 1'b0;
        tick_n(10);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Autonomous bus master that steps the 16-bit LED peripheral through a 4-entry pattern table.
- Shares the 8-bit peripheral bus with the microprocessor through an external arbiter using a REQ/GNT handshake.
- Each step writes the low pattern byte to BASE_ADDR and the high byte to BASE_ADDR+1, matching the LED register-bank layout (0xC0 right bank, 0xC1 left bank).
- A programmable cycle timer paces the steps.

Parameters:
- BASE_ADDR, 8'hC0, address of the right LED bank; the left bank is BASE_ADDR+1.
- DEPTH, 4, pattern table entries; power of two; the index wraps modulo DEPTH.
- PERIOD_W, 16, width of the PERIOD input and the step timer.

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- EN  in  1  sequencer enable, level-sensitive.
- PERIOD  in  PERIOD_W  clock cycles between steps, counted in IDLE.
- PAT_WR  in  1  table write strobe.
- PAT_IDX  in  log2(DEPTH)  table write index.
- PAT_DATA  in  16  table write data.
- BUS_REQ  out  1  bus request to the arbiter.
- BUS_GNT  in  1  bus grant from the arbiter.
- BUS_ADDR  out  8  bus address; 8'h00 when not writing.
- BUS_DATA_OUT  out  8  write data, 8'h00 when not writing; the top level tristates it with BUS_WE.
- BUS_WE  out  1  bus write enable and data-drive enable.
- STEP  out  log2(DEPTH)  index of the next pattern to be written.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE; timer, STEP, BUS_REQ, BUS_WE, BUS_ADDR, BUS_DATA_OUT and BUSY go to 0.
  - All table entries go to 16'h0000.
  - Reset asserted mid-transaction aborts it immediately and releases the bus the same instant.
- Table writes:
  - PAT_WR=1 writes PAT_DATA into entry PAT_IDX at the clock edge.
  - A table write is accepted in every state.
  - A transaction uses a 16-bit snapshot taken on the REQ->WR_LO edge. Table writes after that edge do not affect the transaction in flight.
- Timer:
  - Counts only in IDLE with EN=1; it is cleared whenever EN=0 or the state is not IDLE.
  - The tick fires when count == PERIOD-1. PERIOD=0 is treated as 1, i.e. a tick on the first IDLE cycle.
- State machine, all outputs registered:
  - IDLE: on tick with EN=1, go to REQ.
  - REQ: BUS_REQ=1. When BUS_GNT=1 is sampled, latch the snapshot of entry STEP and go to WR_LO. Otherwise stay in REQ, with no timeout.
  - WR_LO: one cycle. BUS_ADDR=BASE_ADDR, BUS_DATA_OUT=snap[7:0], BUS_WE=1, BUS_REQ=1. Then go to WR_HI.
  - WR_HI: one cycle. BUS_ADDR=BASE_ADDR+1, BUS_DATA_OUT=snap[15:8], BUS_WE=1, BUS_REQ=1. Then go to DONE.
  - DONE: one cycle. BUS_REQ=0, BUS_WE=0, STEP <= STEP+1 (wrapping DEPTH-1 -> 0). Then go to IDLE.
- Latency: grant sampled at edge N gives BUS_WE high for the cycles after edges N+1 and N+2, and BUS_REQ low after edge N+3.
- Once granted, the block ignores BUS_GNT until DONE. The arbiter must hold the grant while BUS_REQ=1.
- EN deasserted:
  - In IDLE: no new step starts.
  - In REQ: the block returns to IDLE on the next edge, drops BUS_REQ, and leaves STEP unchanged.
  - In WR_LO, WR_HI or DONE: the pair is always completed, so the LED banks are never left half-updated. The block then stays in IDLE.
- EN reasserted: the timer restarts from 0, giving a full PERIOD before the next request.
- Minimum step spacing is PERIOD + 4 + grant wait cycles.

Test Plan:
- Reset/idle: hold RESET=0, then release with EN=0 for 100 cycles -> BUS_REQ=0, BUS_WE=0, BUS_ADDR=8'h00, STEP=0, BUSY=0 throughout.
- Basic step:
  - Stimulus: load entry 0=16'hF00F; set PERIOD=10, EN=1; model the arbiter as GNT=REQ delayed one cycle.
  - Required: BUS_REQ rises 10 cycles after EN.
  - Required: next two cycles show (8'hC0, 8'h0F, WE=1), then (8'hC1, 8'hF0, WE=1).
  - Required: STEP=1 after DONE.
- Wrap and order:
  - Stimulus: load entries 16'h0001, 16'h0002, 16'h0004, 16'h0008; run 5 steps.
  - Required: low bytes written are 01, 02, 04, 08, 01; STEP sequence 1, 2, 3, 0, 1.
- Grant stall and drop:
  - Stimulus: hold GNT=0 for 50 cycles -> BUS_REQ stays 1 and no BUS_WE; then raise GNT -> writes follow at N+1 and N+2.
  - Stimulus: separately, drop EN in REQ -> BUS_REQ=0 next cycle and STEP unchanged.
- Snapshot and EN mid-pair:
  - Stimulus: write entry 0=16'hAAAA during the WR_LO cycle.
  - Required: the pair still writes the old value 8'h0F / 8'hF0; the next visit to entry 0 writes AA / AA.
  - Stimulus: drop EN in WR_LO -> WR_HI still occurs, then the block stays in IDLE.
- Async reset mid-transaction: assert RESET=0 between clock edges during WR_HI -> BUS_WE, BUS_REQ and BUS_ADDR are 0 immediately without waiting for a clock edge, and STEP=0.
